// File: rtl/uart_frame_parser.sv
// Frame parser: AA, LEN(1..16), payload, CHK=(LEN+sum) mod 256; replays payload on a valid/ready port.
// Optional inter-byte silence timeout is built only when PARSER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module uart_frame_parser #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int UART_BPS      = 9600,
  parameter int TIMEOUT_BYTES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       len_err,
  output logic       chk_err,
  output logic       ovf_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, GET_LEN, GET_PAY, GET_CHK, SEND} state_e;

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] chk_q, chk_d;
  logic       frame_done_q, frame_done_d;
  logic       len_err_q, len_err_d;
  logic       chk_err_q, chk_err_d;
  logic       ovf_err_q, ovf_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic       wr_en;
  logic       last_wr;
  logic       last_rd;
  logic       timeout_hit;
  logic [7:0] pay_mem [16];

  assign last_wr = ({1'b0, wr_ptr_q} == (len_q - 5'd1));
  assign last_rd = ({1'b0, rd_ptr_q} == (len_q - 5'd1));

`ifdef PARSER_TIMEOUT_EN
  localparam logic [31:0] TO_LIMIT = 32'(CLK_FREQ / UART_BPS * 10 * TIMEOUT_BYTES - 1);

  logic [31:0] to_cnt_q, to_cnt_d;
  logic        in_rx;

  assign in_rx       = (state_q == GET_LEN) || (state_q == GET_PAY) || (state_q == GET_CHK);
  assign timeout_hit = in_rx && !pi_flag && (to_cnt_q == TO_LIMIT);

  always_comb begin
    to_cnt_d = '0;
    if (in_rx && !pi_flag && (to_cnt_q != TO_LIMIT)) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      chk_q         <= '0;
      frame_done_q  <= 1'b0;
      len_err_q     <= 1'b0;
      chk_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      chk_q         <= chk_d;
      frame_done_q  <= frame_done_d;
      len_err_q     <= len_err_d;
      chk_err_q     <= chk_err_d;
      ovf_err_q     <= ovf_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Payload store carries no reset; it is only read after being written in the same frame.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      pay_mem[wr_ptr_q] <= pi_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    chk_d         = chk_q;
    frame_done_d  = 1'b0;
    len_err_d     = 1'b0;
    chk_err_d     = 1'b0;
    ovf_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pi_flag && (pi_data == 8'hAA)) begin
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (pi_flag) begin
          if ((pi_data == 8'd0) || (pi_data > 8'd16)) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            len_d    = pi_data[4:0];
            chk_d    = pi_data;
            wr_ptr_d = '0;
            state_d  = GET_PAY;
          end
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      GET_PAY: begin
        if (pi_flag) begin
          wr_en    = 1'b1;
          chk_d    = chk_q + pi_data;
          wr_ptr_d = wr_ptr_q + 4'd1;
          if (last_wr) begin
            state_d = GET_CHK;
          end
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      GET_CHK: begin
        if (pi_flag) begin
          if (pi_data == chk_q) begin
            rd_ptr_d = '0;
            state_d  = SEND;
          end else begin
            chk_err_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      SEND: begin
        if (out_ready && last_rd) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          if (out_ready) begin
            rd_ptr_d = rd_ptr_q + 4'd1;
          end
          // Overflow pulse yields to frame_done so only one status pulse fires per cycle.
          ovf_err_d = pi_flag;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid   = (state_q == SEND);
    out_data    = (state_q == SEND) ? pay_mem[rd_ptr_q] : 8'h00;
    frame_done  = frame_done_q;
    len_err     = len_err_q;
    chk_err     = chk_err_q;
    ovf_err     = ovf_err_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: scoreboard queue of expected payload bytes plus pulse counters.
// Define PARSER_TIMEOUT_EN for both files to exercise the timeout path.
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int CLK_FREQ      = 1_000_000;
  localparam int UART_BPS      = 100_000;
  localparam int TIMEOUT_BYTES = 3;
  localparam int TO_CYCLES     = CLK_FREQ / UART_BPS * 10 * TIMEOUT_BYTES;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       len_err;
  logic       chk_err;
  logic       ovf_err;
  logic       timeout_err;

  uart_frame_parser #(
    .CLK_FREQ     (CLK_FREQ),
    .UART_BPS     (UART_BPS),
    .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .pi_data    (pi_data),
    .pi_flag    (pi_flag),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .len_err    (len_err),
    .chk_err    (chk_err),
    .ovf_err    (ovf_err),
    .timeout_err(timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];
  int fd_cnt = 0, len_cnt = 0, chk_cnt = 0, ovf_cnt = 0, to_cnt = 0;
  int valid_cnt = 0, hold_cnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] held = 8'h00;
  int base_fd, base_len, base_chk, base_ovf, base_to, base_valid, base_pulses;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int pulseTotal();
    return fd_cnt + len_cnt + chk_cnt + ovf_cnt + to_cnt;
  endfunction

  // Inputs change 2ns after the rising edge; this monitor samples on the falling edge.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid) valid_cnt++;
      if (frame_done) fd_cnt++;
      if (len_err) len_cnt++;
      if (chk_err) chk_cnt++;
      if (ovf_err) ovf_cnt++;
      if (timeout_err) to_cnt++;
      if (frame_done || len_err || chk_err || ovf_err || timeout_err)
        checkOutput("one_pulse", 32'($countones({frame_done, len_err, chk_err, ovf_err, timeout_err})), 32'd1);
      if (stall_prev && out_valid) begin
        hold_cnt++;
        checkOutput("hold_data", {24'd0, out_data}, {24'd0, held});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("spurious_valid", {31'd0, out_valid}, 32'd0);
        else checkOutput("payload", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge sys_clk);
    #2;
    pi_data = b;
    pi_flag = 1'b1;
    @(posedge sys_clk);
    #2;
    pi_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic waitDrain(input string tag, input int budget, input bit toggle);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sys_clk);
      #2;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    idle(3);
  endtask

  task automatic snapshot();
    base_fd = fd_cnt; base_len = len_cnt; base_chk = chk_cnt;
    base_ovf = ovf_cnt; base_to = to_cnt; base_valid = valid_cnt;
    base_pulses = pulseTotal();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sys_rst = 1'b1; pi_data = 8'h00; pi_flag = 1'b0; out_ready = 1'b0;
    #1;
    checkOutput("reset_outputs", {19'd0, out_data, out_valid, frame_done, len_err, chk_err, ovf_err, timeout_err}, 32'd0);
    idle(3);
    sys_rst = 1'b0;
    idle(2);
    checkOutput("post_reset_idle", {24'd0, out_data}, 32'd0);

    // Frame 1: three bytes streamed back-to-back with ready held high.
    snapshot();
    out_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    applyStimulus(8'hAA); applyStimulus(8'h03);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    applyStimulus(8'h69);
    checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
    @(negedge sys_clk); checkOutput("stream_b0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
    @(negedge sys_clk); checkOutput("stream_b1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
    @(negedge sys_clk); checkOutput("stream_b2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h33});
    @(negedge sys_clk); checkOutput("done_pulse", {30'd0, out_valid, frame_done}, 32'd1);
    idle(2);
    checkOutput("f1_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("f1_done_cnt", 32'(fd_cnt - base_fd), 32'd1);

    // Frame 2: checksum wraps past 0xFF; ready toggles during delivery.
    snapshot();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h02);
    applyStimulus(8'hAA); applyStimulus(8'h02);
    applyStimulus(8'hFF); applyStimulus(8'h02); applyStimulus(8'h03);
    waitDrain("f2_drain", 40, 1'b1);
    checkOutput("f2_hold_seen", {31'd0, hold_cnt > 0}, 32'd1);
    checkOutput("f2_done_cnt", 32'(fd_cnt - base_fd), 32'd1);

    // Frame 3: bad checksum emits nothing, then a good single-byte frame.
    snapshot();
    applyStimulus(8'hAA); applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h00);
    idle(3);
    checkOutput("chk_err_cnt", 32'(chk_cnt - base_chk), 32'd1);
    checkOutput("chk_no_valid", 32'(valid_cnt - base_valid), 32'd0);
    exp_q.push_back(8'h05);
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h05); applyStimulus(8'h06);
    waitDrain("f3_drain", 20, 1'b0);
    checkOutput("f3_done_cnt", 32'(fd_cnt - base_fd), 32'd1);

    // Length errors at both ends of the legal range, then a stray byte and a good frame.
    snapshot();
    applyStimulus(8'hAA); applyStimulus(8'h00);
    idle(2);
    checkOutput("len_zero", 32'(len_cnt - base_len), 32'd1);
    applyStimulus(8'hAA); applyStimulus(8'h11);
    idle(2);
    checkOutput("len_17", 32'(len_cnt - base_len), 32'd2);
    applyStimulus(8'h55);
    exp_q.push_back(8'h05);
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h05); applyStimulus(8'h06);
    waitDrain("f4_drain", 20, 1'b0);
    checkOutput("f4_done_cnt", 32'(fd_cnt - base_fd), 32'd1);

    // Overflow: byte arrives while the consumer is stalled.
    snapshot();
    out_ready = 1'b0;
    exp_q.push_back(8'h05);
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h05); applyStimulus(8'h06);
    idle(2);
    checkOutput("ovf_waiting", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h05});
    applyStimulus(8'h77);
    idle(2);
    checkOutput("ovf_cnt", 32'(ovf_cnt - base_ovf), 32'd1);
    out_ready = 1'b1;
    waitDrain("f5_drain", 20, 1'b0);
    checkOutput("f5_done_cnt", 32'(fd_cnt - base_fd), 32'd1);

    // Reset mid-frame and mid-SEND: everything clears, nothing follows release.
    snapshot();
    applyStimulus(8'hAA); applyStimulus(8'h02);
    sys_rst = 1'b1;
    #1;
    checkOutput("rst_midframe", {19'd0, out_data, out_valid, frame_done, len_err, chk_err, ovf_err, timeout_err}, 32'd0);
    idle(2);
    sys_rst = 1'b0;
    out_ready = 1'b0;
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h05); applyStimulus(8'h06);
    checkOutput("rst_send_valid", {31'd0, out_valid}, 32'd1);
    sys_rst = 1'b1;
    #1;
    checkOutput("rst_midsend", {19'd0, out_data, out_valid, frame_done, len_err, chk_err, ovf_err, timeout_err}, 32'd0);
    idle(2);
    sys_rst = 1'b0;
    base_valid = valid_cnt;
    idle(TO_CYCLES + 20);
    checkOutput("rst_no_pulses", 32'(pulseTotal() - base_pulses), 32'd0);
    checkOutput("rst_no_valid", 32'(valid_cnt - base_valid), 32'd0);
    out_ready = 1'b1;

`ifdef PARSER_TIMEOUT_EN
    snapshot();
    applyStimulus(8'hAA); applyStimulus(8'h02);
    for (int n = 0; n < TO_CYCLES + 20 && to_cnt == base_to; n++) idle(1);
    idle(5);
    checkOutput("timeout_cnt", 32'(to_cnt - base_to), 32'd1);
    exp_q.push_back(8'h05);
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h05); applyStimulus(8'h06);
    waitDrain("to_drain", 20, 1'b0);
    checkOutput("to_done_cnt", 32'(fd_cnt - base_fd), 32'd1);
`else
    snapshot();
    applyStimulus(8'hAA); applyStimulus(8'h02);
    idle(TO_CYCLES + 50);
    checkOutput("no_timeout", 32'(to_cnt - base_to), 32'd0);
    exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    applyStimulus(8'h05); applyStimulus(8'h06); applyStimulus(8'h0D);
    waitDrain("wait_drain", 20, 1'b0);
    checkOutput("wait_done_cnt", 32'(fd_cnt - base_fd), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 The module SHALL have parameter UART_BPS, default 9600, meaning line baud rate, used only for timeout sizing.
REQ-003 The module SHALL have parameter TIMEOUT_BYTES, default 3, meaning inter-byte silence limit in byte times (10 bit times each).
REQ-004 The module SHALL have port sys_clk, input, 1 bit: single clock, rising edge.
REQ-005 The module SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port pi_data, input, 8 bits: received byte from the UART receiver.
REQ-007 The module SHALL have port pi_flag, input, 1 bit: one-cycle strobe marking pi_data valid.
REQ-008 The module SHALL have port out_data, output, 8 bits: payload byte.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 The module SHALL have ports frame_done, len_err, chk_err, ovf_err and timeout_err, each an output of 1 bit carrying a one-cycle status pulse.

Function
REQ-012 Frame format SHALL be: header 0xAA, LEN (1..16), LEN payload bytes, CHK, where CHK = (LEN + sum of payload) mod 256.
REQ-013 The FSM SHALL have states IDLE, GET_LEN, GET_PAY, GET_CHK and SEND, and SHALL enter IDLE at reset.
REQ-014 In IDLE, a pi_flag with pi_data==0xAA SHALL move the FSM to GET_LEN; any other byte SHALL be discarded silently.
REQ-015 In GET_LEN, LEN of 0 or above 16 SHALL pulse len_err and return the FSM to IDLE; otherwise the FSM SHALL store LEN, initialise the checksum to LEN, and go to GET_PAY.
REQ-016 In GET_PAY, each byte SHALL be written to a 16x8 buffer at write pointer 0..LEN-1 and added to the 8-bit checksum (wrap-around, no carry kept); after byte LEN the FSM SHALL go to GET_CHK.
REQ-017 In GET_CHK, a match SHALL move the FSM to SEND with read pointer 0 and out_valid high on the next cycle; a mismatch SHALL pulse chk_err, return to IDLE, and emit no payload.
REQ-018 In SEND, out_data SHALL equal buf[rd_ptr], out_valid SHALL be held high, and rd_ptr SHALL advance only on out_valid && out_ready; out_data SHALL be stable while out_ready is low.
REQ-019 The handshake on byte LEN SHALL deassert out_valid, pulse frame_done, and return the FSM to IDLE, all on the following cycle.
REQ-020 A pi_flag during SEND SHALL be dropped and SHALL pulse ovf_err; a 0xAA received during SEND SHALL NOT start a frame.
REQ-021 Latency SHALL be one cycle from the pi_flag of a valid CHK byte to out_valid=1.
REQ-022 Error pulses SHALL be asserted one cycle after the triggering pi_flag; at most one status pulse SHALL be asserted per cycle.

Reset
REQ-023 Asserting sys_rst SHALL immediately clear the FSM to IDLE, clear pointers, checksum, LEN and timeout counter, and drive out_data=0x00, out_valid=0 and all status pulses to 0.
REQ-024 Reset asserted mid-frame or mid-SEND SHALL discard the frame, and no pulse SHALL follow the release of reset.
REQ-025 Buffer contents SHALL NOT require reset.

Configuration
REQ-026 When macro PARSER_TIMEOUT_EN is defined, a counter SHALL run in GET_LEN, GET_PAY and GET_CHK, SHALL clear on each pi_flag, and on reaching CLK_FREQ/UART_BPS*10*TIMEOUT_BYTES-1 SHALL pulse timeout_err and return the FSM to IDLE; the counter SHALL be held at 0 in IDLE and SEND.
REQ-027 When PARSER_TIMEOUT_EN is undefined, no counter SHALL be built, timeout_err SHALL be tied to 0, and partial frames SHALL wait indefinitely.
REQ-028 If timeout expiry and pi_flag occur in the same cycle, pi_flag SHALL win and the counter SHALL clear.

Verification
REQ-029 The bench SHALL send AA 03 11 22 33 69 with out_ready=1 -> out_data 11,22,33 on consecutive cycles, then one frame_done pulse.
REQ-030 The bench SHALL send AA 02 FF 02 03 (checksum wraps) with out_ready toggling 1/0 -> 0xFF, 0x02 delivered with out_data stable while out_ready=0, then frame_done.
REQ-031 The bench SHALL send AA 02 10 20 00 -> one chk_err pulse, out_valid never high; then send AA 01 05 06 -> 0x05 delivered.
REQ-032 The bench SHALL send AA 00, and separately AA 11 -> one len_err pulse each, FSM back in IDLE.
REQ-033 The bench SHALL send AA 01 05 06 with out_ready=0, then byte 0x77 -> one ovf_err pulse, 0x05 still delivered when out_ready=1.
REQ-034 The bench SHALL, with PARSER_TIMEOUT_EN defined, send AA 02 then stay silent for TIMEOUT_BYTES byte times -> one timeout_err pulse; also assert sys_rst after AA 02 -> all outputs 0, no pulses after release.
